// File: rtl/gemm_issue_ctrl.sv
// rtl/gemm_issue_ctrl.sv - decode-stage GEMM command queue, dispatcher and in-flight tracker
module gemm_issue_ctrl #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       instruction,
    input  logic                              instr_valid,
    input  logic                              stall,
    input  logic                              flush,
    input  logic [XLEN-1:0]                   rs1_data,
    input  logic [XLEN-1:0]                   rs2_data,
    input  logic                              gemm_ready,
    input  logic                              gemm_done,
    output logic                              gemm_valid,
    output logic [6:0]                        gemm_op,
    output logic [XLEN-1:0]                   gemm_a,
    output logic [XLEN-1:0]                   gemm_b,
    output logic                              gemm_stall,
    output logic                              gemm_busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              is_GemmInstr_ppl,
    output logic                              gemm_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = 7 + 2 * XLEN;

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          ppl_q, ppl_d, err_q, err_d;

    logic is_gemm, is_issue, is_fence, is_illegal;
    logic fifo_empty, fifo_full, accept, push, pop, done_ok;

    always_comb begin
        is_gemm    = instr_valid && (instruction[6:0] == 7'b0001011);
        is_issue   = is_gemm && (instruction[14:12] == 3'b000);
        is_fence   = is_gemm && (instruction[14:12] == 3'b001);
        is_illegal = is_gemm && !is_issue && !is_fence;

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(DEPTH));
        gemm_busy  = !fifo_empty || (inflight_q != '0);
        gemm_stall = (is_issue && fifo_full) || (is_fence && gemm_busy);

        accept     = is_gemm && !stall && !flush && !gemm_stall;
        push       = accept && is_issue;
        // gemm_valid depends only on registered state, never on gemm_ready
        gemm_valid = !fifo_empty && (inflight_q < IW'(MAX_INFLIGHT));
        pop        = gemm_valid && gemm_ready;
        done_ok    = gemm_done && (inflight_q != '0);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        inflight_d = inflight_q;
        if (pop && !done_ok) inflight_d = inflight_q + 1'b1;
        else if (done_ok && !pop) inflight_d = inflight_q - 1'b1;

        ppl_d = flush ? 1'b0 : (stall ? ppl_q : accept);

        err_d = err_q
              || (is_illegal && !stall && !flush)
              || (gemm_done && (inflight_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            ppl_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ppl_q      <= ppl_d;
            err_q      <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {instruction[31:25], rs1_data, rs2_data};
    end

    assign {gemm_op, gemm_a, gemm_b} = mem_q[rd_ptr_q];
    assign inflight         = inflight_q;
    assign is_GemmInstr_ppl = ppl_q;
    assign gemm_err         = err_q;
endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// tb/tb_gemm_issue_ctrl.sv - randomized and directed bench for gemm_issue_ctrl
module tb_gemm_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int MAXI  = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] instruction = '0, rs1_data = '0, rs2_data = '0;
    logic        instr_valid = 1'b0, stall = 1'b0, flush = 1'b0, gemm_ready = 1'b0, gemm_done = 1'b0;
    logic        gemm_valid, gemm_stall, gemm_busy, is_GemmInstr_ppl, gemm_err;
    logic [6:0]  gemm_op;
    logic [31:0] gemm_a, gemm_b;
    logic [1:0]  inflight;

    gemm_issue_ctrl #(.XLEN(32), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .gemm_ready(gemm_ready), .gemm_done(gemm_done), .gemm_valid(gemm_valid),
        .gemm_op(gemm_op), .gemm_a(gemm_a), .gemm_b(gemm_b), .gemm_stall(gemm_stall),
        .gemm_busy(gemm_busy), .inflight(inflight), .is_GemmInstr_ppl(is_GemmInstr_ppl),
        .gemm_err(gemm_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [6:0] op; logic [31:0] a; logic [31:0] b;} cmd_t;
    cmd_t mq[$];
    int   m_inf = 0;
    bit   m_err = 0, m_ppl = 0;
    int   n_vec = 0, n_err = 0;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'h0, f3, 5'h0, 7'b0001011};
    endfunction

    function automatic bit m_busy();
        return mq.size() != 0 || m_inf != 0;
    endfunction

    function automatic bit m_valid();
        return mq.size() != 0 && m_inf < MAXI;
    endfunction

    function automatic bit m_gstall();
        bit gem;
        gem = instr_valid && instruction[6:0] == 7'b0001011;
        return gem && ((instruction[14:12] == 3'd0 && mq.size() == DEPTH) ||
                       (instruction[14:12] == 3'd1 && m_busy()));
    endfunction

    task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input bit st, input bit fl, input bit rdy, input bit dn);
        instr_valid = iv; instruction = ins; rs1_data = a; rs2_data = b;
        stall = st; flush = fl; gemm_ready = rdy; gemm_done = dn;
        #1;
    endtask

    task automatic idle(input bit rdy, input bit dn);
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, rdy, dn);
    endtask

    // Advance one edge and apply the same edge to the reference model
    task automatic tick();
        bit gem, acc, disp, dn;
        logic [2:0] f3;
        int pre;
        @(posedge clk);
        gem  = instr_valid && instruction[6:0] == 7'b0001011;
        f3   = instruction[14:12];
        acc  = gem && !stall && !flush && !m_gstall();
        disp = m_valid() && gemm_ready;
        dn   = gemm_done;
        pre  = m_inf;
        if (gem && f3 > 3'd1 && !stall && !flush) m_err = 1;
        if (dn && pre == 0) m_err = 1;
        if (flush) m_ppl = 0; else if (!stall) m_ppl = acc;
        if (disp) mq.delete(0);
        if (acc && f3 == 3'd0) mq.push_back('{instruction[31:25], rs1_data, rs2_data});
        m_inf = pre + (disp ? 1 : 0) - ((dn && pre > 0) ? 1 : 0);
        #1;
    endtask

    task automatic do_reset();
        idle(0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_inf = 0; m_err = 0; m_ppl = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int k;
        for (k = 0; k < 60 && m_busy(); k++) begin
            idle(1, m_inf > 0);
            n_vec++;
            if (gemm_valid !== m_valid()) begin n_err++; $display("FAIL settle_valid: got %b want %b", gemm_valid, m_valid()); end
            if (m_valid()) begin
                n_vec++;
                if ({gemm_op, gemm_a, gemm_b} !== {mq[0].op, mq[0].a, mq[0].b}) begin
                    n_err++; $display("FAIL settle_payload: got %h/%h/%h want %h/%h/%h", gemm_op, gemm_a, gemm_b, mq[0].op, mq[0].a, mq[0].b);
                end
            end
            tick();
        end
        idle(0, 0);
        n_vec++;
        if (gemm_busy !== 1'b0 || m_busy()) begin n_err++; $display("FAIL settle_drain: busy got %b want 0", gemm_busy); end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({gemm_valid, gemm_busy, gemm_err, is_GemmInstr_ppl, inflight} !== 6'b0) begin
            n_err++; $display("FAIL reset_state: got %b want 000000", {gemm_valid, gemm_busy, gemm_err, is_GemmInstr_ppl, inflight});
        end
        drive(1, mk(7'h01, 3'b001), 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (gemm_stall !== 1'b0) begin n_err++; $display("FAIL reset_fence_stall: got %b want 0", gemm_stall); end
        do_reset();
    endtask

    task automatic test_single_issue();
        drive(1, mk(7'h05, 3'b000), 32'h1000, 32'h2000, 0, 0, 1, 0);
        n_vec++;
        if (gemm_valid !== 1'b0 || gemm_stall !== 1'b0) begin n_err++; $display("FAIL single_pre: valid/stall got %b%b want 00", gemm_valid, gemm_stall); end
        tick();
        idle(1, 0);
        n_vec++;
        if ({gemm_valid, gemm_op, gemm_a, gemm_b} !== {1'b1, 7'h05, 32'h1000, 32'h2000}) begin
            n_err++; $display("FAIL single_head: got %b %h %h %h want 1 05 1000 2000", gemm_valid, gemm_op, gemm_a, gemm_b);
        end
        n_vec++;
        if (is_GemmInstr_ppl !== 1'b1) begin n_err++; $display("FAIL single_ppl: got %b want 1", is_GemmInstr_ppl); end
        tick();
        n_vec++;
        if (inflight !== 2'd1 || gemm_valid !== 1'b0) begin n_err++; $display("FAIL single_inflight: got %0d/%b want 1/0", inflight, gemm_valid); end
        idle(0, 1);
        tick();
        idle(0, 0);
        n_vec++;
        if (inflight !== 2'd0 || gemm_busy !== 1'b0) begin n_err++; $display("FAIL single_done: got %0d/%b want 0/0", inflight, gemm_busy); end
    endtask

    task automatic test_backpressure();
        cmd_t exp[5];
        int idx;
        for (int i = 0; i < 5; i++) begin
            exp[i].op = 7'($urandom); exp[i].a = $urandom; exp[i].b = $urandom;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, mk(exp[i].op, 3'b000), exp[i].a, exp[i].b, 0, 0, 0, 0);
            n_vec++;
            if (gemm_stall !== (i == 4)) begin n_err++; $display("FAIL full_stall%0d: got %b want %b", i, gemm_stall, i == 4); end
            if (i < 4) tick();
        end
        drive(1, mk(exp[4].op, 3'b000), exp[4].a, exp[4].b, 0, 0, 1, 0);
        n_vec++;
        if (gemm_stall !== 1'b1 || gemm_valid !== 1'b1 || gemm_a !== exp[0].a) begin
            n_err++; $display("FAIL full_first_pop: stall/valid/a got %b%b %h want 11 %h", gemm_stall, gemm_valid, gemm_a, exp[0].a);
        end
        tick();
        n_vec++;
        if (gemm_stall !== 1'b0 || gemm_a !== exp[1].a) begin
            n_err++; $display("FAIL full_fifth_accept: stall/a got %b %h want 0 %h", gemm_stall, gemm_a, exp[1].a);
        end
        tick();
        idx = 2;
        for (int k = 0; k < 40 && idx < 5; k++) begin
            idle(1, m_inf > 0);
            if (gemm_valid === 1'b1) begin
                n_vec++;
                if (gemm_op !== exp[idx].op || gemm_a !== exp[idx].a || gemm_b !== exp[idx].b) begin
                    n_err++; $display("FAIL full_order%0d: got %h/%h/%h want %h/%h/%h", idx, gemm_op, gemm_a, gemm_b, exp[idx].op, exp[idx].a, exp[idx].b);
                end
                idx++;
            end
            tick();
        end
        n_vec++;
        if (idx != 5) begin n_err++; $display("FAIL full_count: dispatched %0d want 5", idx); end
        settle();
    endtask

    task automatic test_inflight_cap();
        logic [31:0] a3;
        for (int i = 0; i < 3; i++) begin
            a3 = $urandom;
            drive(1, mk(7'($urandom), 3'b000), a3, $urandom, 0, 0, 1, 0);
            tick();
        end
        idle(1, 0);
        n_vec++;
        if (gemm_valid !== 1'b0 || inflight !== 2'd2 || gemm_busy !== 1'b1) begin
            n_err++; $display("FAIL cap_block: valid/inflight/busy got %b/%0d/%b want 0/2/1", gemm_valid, inflight, gemm_busy);
        end
        idle(0, 1);
        tick();
        idle(0, 0);
        n_vec++;
        if (gemm_valid !== 1'b1 || gemm_a !== a3) begin n_err++; $display("FAIL cap_reenable: valid/a got %b %h want 1 %h", gemm_valid, gemm_a, a3); end
        settle();
    endtask

    task automatic test_fence();
        for (int i = 0; i < 2; i++) begin
            drive(1, mk(7'($urandom), 3'b000), $urandom, $urandom, 0, 0, 1, 0);
            tick();
        end
        idle(1, 0);
        tick();
        drive(1, mk(7'h00, 3'b001), 0, 0, 0, 0, 0, 1);
        n_vec++;
        if (gemm_stall !== 1'b1 || inflight !== 2'd2) begin n_err++; $display("FAIL fence_hold2: stall/inflight got %b/%0d want 1/2", gemm_stall, inflight); end
        tick();
        n_vec++;
        if (gemm_stall !== 1'b1 || inflight !== 2'd1) begin n_err++; $display("FAIL fence_hold1: stall/inflight got %b/%0d want 1/1", gemm_stall, inflight); end
        tick();
        drive(1, mk(7'h00, 3'b001), 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (gemm_stall !== 1'b0 || is_GemmInstr_ppl !== 1'b0) begin n_err++; $display("FAIL fence_release: stall/ppl got %b/%b want 0/0", gemm_stall, is_GemmInstr_ppl); end
        tick();
        idle(0, 0);
        n_vec++;
        if (is_GemmInstr_ppl !== 1'b1) begin n_err++; $display("FAIL fence_ppl: got %b want 1", is_GemmInstr_ppl); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2; i++) begin
            drive(1, mk(7'($urandom), 3'b000), $urandom, $urandom, 0, 0, 1, 0);
            tick();
        end
        idle(1, 1);
        n_vec++;
        if (gemm_valid !== 1'b1 || inflight !== 2'd1) begin n_err++; $display("FAIL simul_pre: valid/inflight got %b/%0d want 1/1", gemm_valid, inflight); end
        tick();
        n_vec++;
        if (inflight !== 2'd1) begin n_err++; $display("FAIL simul_inflight: got %0d want 1", inflight); end
        settle();
        drive(1, mk(7'h22, 3'b000), $urandom, $urandom, 0, 1, 0, 0);
        tick();
        idle(0, 0);
        n_vec++;
        if (is_GemmInstr_ppl !== 1'b0 || gemm_valid !== 1'b0 || gemm_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_issue: ppl/valid/busy got %b%b%b want 000", is_GemmInstr_ppl, gemm_valid, gemm_busy);
        end
        drive(1, mk(7'h33, 3'b000), $urandom, $urandom, 0, 0, 0, 0);
        tick();
        drive(1, mk(7'h44, 3'b000), $urandom, $urandom, 1, 0, 0, 0);
        tick();
        idle(0, 0);
        n_vec++;
        if (is_GemmInstr_ppl !== 1'b1) begin n_err++; $display("FAIL stall_ppl_hold: got %b want 1", is_GemmInstr_ppl); end
        settle();
    endtask

    task automatic test_errors();
        do_reset();
        idle(0, 1);
        tick();
        idle(0, 0);
        n_vec++;
        if (gemm_err !== 1'b1 || inflight !== 2'd0) begin n_err++; $display("FAIL err_done0: err/inflight got %b/%0d want 1/0", gemm_err, inflight); end
        do_reset();
        drive(1, mk(7'h11, 3'b111), $urandom, $urandom, 0, 0, 1, 0);
        n_vec++;
        if (gemm_stall !== 1'b0 || gemm_err !== 1'b0) begin n_err++; $display("FAIL err_illegal_pre: stall/err got %b%b want 00", gemm_stall, gemm_err); end
        tick();
        idle(1, 0);
        n_vec++;
        if (gemm_err !== 1'b1 || gemm_valid !== 1'b0 || gemm_busy !== 1'b0) begin
            n_err++; $display("FAIL err_illegal: err/valid/busy got %b%b%b want 100", gemm_err, gemm_valid, gemm_busy);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(7'($urandom), 3'b000), $urandom, $urandom, 0, 0, i == 0, 0);
            tick();
        end
        idle(0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({gemm_valid, gemm_busy, gemm_err, is_GemmInstr_ppl, inflight} !== 6'b0) begin
            n_err++; $display("FAIL reset_mid: got %b want 000000", {gemm_valid, gemm_busy, gemm_err, is_GemmInstr_ppl, inflight});
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_inf = 0; m_err = 0; m_ppl = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [6:0]  opc;
        int r;
        for (int c = 0; c < 400; c++) begin
            r   = $urandom_range(0, 9);
            f3  = (r < 6) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom_range(2, 7));
            opc = ($urandom_range(0, 7) == 0) ? 7'b0110011 : 7'b0001011;
            drive($urandom_range(0, 3) != 0, {7'($urandom), 10'($urandom), f3, 5'($urandom), opc},
                  $urandom, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0, (m_inf > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0));
            n_vec++;
            if (gemm_stall !== m_gstall() || gemm_valid !== m_valid() || gemm_busy !== m_busy()) begin
                n_err++; $display("FAIL rand_ctl c%0d: stall/valid/busy got %b%b%b want %b%b%b", c, gemm_stall, gemm_valid, gemm_busy, m_gstall(), m_valid(), m_busy());
            end
            n_vec++;
            if (inflight !== 2'(m_inf) || gemm_err !== m_err || is_GemmInstr_ppl !== m_ppl) begin
                n_err++; $display("FAIL rand_state c%0d: inflight/err/ppl got %0d%b%b want %0d%b%b", c, inflight, gemm_err, is_GemmInstr_ppl, m_inf, m_err, m_ppl);
            end
            if (m_valid()) begin
                n_vec++;
                if ({gemm_op, gemm_a, gemm_b} !== {mq[0].op, mq[0].a, mq[0].b}) begin
                    n_err++; $display("FAIL rand_payload c%0d: got %h/%h/%h want %h/%h/%h", c, gemm_op, gemm_a, gemm_b, mq[0].op, mq[0].a, mq[0].b);
                end
            end
            tick();
        end
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_issue();
        test_backpressure();
        test_inflight_cap();
        test_fence();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
